// File: rtl/ph1_cfg_pkg.sv
// Shared types for the Phase 1 configuration sequencer: bank targets, FSM states,
// bank length lookup and flow-flag bit positions.
package ph1_cfg_pkg;

    localparam int CNT_W  = 8;
    localparam int FLAG_W = 8;

    // Flow flag positions: ovf/unf pairs for frac, 2.4 MHz, 2 MHz and 1 MHz stages.
    localparam int FLG_FRAC_OVF = 0;
    localparam int FLG_FRAC_UNF = 1;
    localparam int FLG_2_4_OVF  = 2;
    localparam int FLG_2_4_UNF  = 3;
    localparam int FLG_2_OVF    = 4;
    localparam int FLG_2_UNF    = 5;
    localparam int FLG_1_OVF    = 6;
    localparam int FLG_1_UNF    = 7;

    typedef enum logic [2:0] {
        TGT_FRAC        = 3'd0,
        TGT_IIR_2_4_NUM = 3'd1,
        TGT_IIR_2_4_DEN = 3'd2,
        TGT_IIR_2_NUM   = 3'd3,
        TGT_IIR_2_DEN   = 3'd4,
        TGT_IIR_1_NUM   = 3'd5,
        TGT_IIR_1_DEN   = 3'd6,
        TGT_BYPASS      = 3'd7
    } cfg_target_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_CHECK     = 3'd2,
        ST_WAIT_SAFE = 3'd3,
        ST_COMMIT    = 3'd4,
        ST_ERR       = 3'd5
    } cfg_state_e;

    // Numerator banks sit on odd targets, denominator banks on even IIR targets.
    function automatic logic [CNT_W-1:0] exp_len(input cfg_target_e tgt,
                                                 input int n_tap,
                                                 input int num_depth,
                                                 input int den_depth);
        logic [CNT_W-1:0] len;
        case (tgt)
            TGT_FRAC:   len = CNT_W'(n_tap);
            TGT_BYPASS: len = CNT_W'(1);
            default:    len = tgt[0] ? CNT_W'(num_depth) : CNT_W'(den_depth);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ph1_sticky_status.sv
// Sticky flow status: each bit latches high on its raw flag, drops on clr; set wins.
// One-cycle latency from flag to sticky output; no backpressure.
module ph1_sticky_status
    import ph1_cfg_pkg::*;
#(
    parameter int WIDTH = FLAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] set_flags,
    input  logic             clr,
    output logic [WIDTH-1:0] sticky
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky & ~{WIDTH{clr}}) | set_flags;
        end
    end

endmodule

// File: rtl/ph1_cfg_ctrl.sv
// Phase 1 coefficient sequencer: assembles a bank from a valid/ready word stream and commits
// it at a chain safe point; wr_en three cycles after the last word at best, cfg_ready low CHECK..COMMIT.
module ph1_cfg_ctrl
    import ph1_cfg_pkg::*;
#(
    parameter int COEFF_WIDTH     = 20,
    parameter int N_TAP           = 72,
    parameter int NUM_COEFF_DEPTH = 3,
    parameter int DEN_COEFF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [2:0]                   cfg_target,
    input  logic                         cfg_last,
    input  logic [COEFF_WIDTH-1:0]       cfg_data,
    input  logic                         commit_ok,
    output logic [N_TAP*COEFF_WIDTH-1:0] coeff_bus,
    output logic [6:0]                   wr_en,
    output logic                         iir_bypass_2_4,
    output logic                         iir_bypass_2,
    output logic                         iir_bypass_1,
    input  logic [FLAG_W-1:0]            flow_flags,
    output logic [FLAG_W-1:0]            sticky_flags,
    input  logic                         sticky_clr,
    output logic                         cfg_done,
    output logic                         cfg_err,
    output logic                         busy
);

    localparam int               IDX_W   = $clog2(N_TAP);
    localparam logic [CNT_W-1:0] N_TAP_C = CNT_W'(N_TAP);

    cfg_state_e             state;
    cfg_target_e            tgt_q;
    cfg_target_e            tgt_in;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CNT_W-1:0]       exp_q;
    logic [CNT_W-1:0]       wr_idx;
    logic                   xfer;
    logic [COEFF_WIDTH-1:0] shadow [N_TAP];

    assign tgt_in  = cfg_target_e'(cfg_target);
    assign xfer    = cfg_valid && cfg_ready;
    assign cnt_inc = cnt + CNT_W'(1);
    assign exp_q   = exp_len(tgt_q, N_TAP, NUM_COEFF_DEPTH, DEN_COEFF_DEPTH);
    assign wr_idx  = (state == ST_IDLE) ? '0 : cnt;

    // Out-of-range writes are dropped rather than wrapped; the FSM rejects such a bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_TAP; i++) begin
                shadow[i] <= '0;
            end
        end else if (xfer && (wr_idx < N_TAP_C)) begin
            shadow[wr_idx[IDX_W-1:0]] <= cfg_data;
        end
    end

    for (genvar i = 0; i < N_TAP; i++) begin : g_bus
        assign coeff_bus[i*COEFF_WIDTH +: COEFF_WIDTH] = shadow[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            tgt_q          <= TGT_FRAC;
            cnt            <= '0;
            wr_en          <= '0;
            cfg_done       <= 1'b0;
            cfg_err        <= 1'b0;
            cfg_ready      <= 1'b1;
            busy           <= 1'b0;
            iir_bypass_2_4 <= 1'b0;
            iir_bypass_2   <= 1'b0;
            iir_bypass_1   <= 1'b0;
        end else begin
            wr_en    <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        tgt_q <= tgt_in;
                        cnt   <= CNT_W'(1);
                        busy  <= 1'b1;
                        if (cfg_last) begin
                            state     <= ST_CHECK;
                            cfg_ready <= 1'b0;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        cnt <= cnt_inc;
                        if (tgt_in != tgt_q) begin
                            state     <= ST_ERR;
                            cfg_ready <= 1'b0;
                            cfg_err   <= 1'b1;
                        end else if (cfg_last) begin
                            state     <= ST_CHECK;
                            cfg_ready <= 1'b0;
                        end else if (cnt_inc >= exp_q) begin
                            state     <= ST_ERR;
                            cfg_ready <= 1'b0;
                            cfg_err   <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (cnt == exp_q) begin
                        state <= ST_WAIT_SAFE;
                    end else begin
                        state   <= ST_ERR;
                        cfg_err <= 1'b1;
                    end
                end
                ST_WAIT_SAFE: begin
                    if (commit_ok) begin
                        state    <= ST_COMMIT;
                        cfg_done <= 1'b1;
                        if (tgt_q == TGT_BYPASS) begin
                            iir_bypass_2_4 <= shadow[0][0];
                            iir_bypass_2   <= shadow[0][1];
                            iir_bypass_1   <= shadow[0][2];
                        end else begin
                            wr_en <= 7'(1) << tgt_q;
                        end
                    end
                end
                default: begin
                    // COMMIT and ERR both last one cycle and reopen the input.
                    state     <= ST_IDLE;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    ph1_sticky_status #(
        .WIDTH (FLAG_W)
    ) u_sticky (
        .clk       (clk),
        .rst       (rst),
        .set_flags (flow_flags),
        .clr       (sticky_clr),
        .sticky    (sticky_flags)
    );

endmodule

// File: tb/tb_ph1_cfg_ctrl.sv
// Directed bench for ph1_cfg_ctrl: bank loads, commit gating, rejects, bypass, reset abort, sticky flags.
module tb_ph1_cfg_ctrl;

    localparam int W  = 20;
    localparam int NT = 72;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [2:0]      cfg_target;
    logic            cfg_last;
    logic [W-1:0]    cfg_data;
    logic            commit_ok;
    logic [NT*W-1:0] coeff_bus;
    logic [6:0]      wr_en;
    logic            iir_bypass_2_4;
    logic            iir_bypass_2;
    logic            iir_bypass_1;
    logic [7:0]      flow_flags;
    logic [7:0]      sticky_flags;
    logic            sticky_clr;
    logic            cfg_done;
    logic            cfg_err;
    logic            busy;

    int checks = 0;
    int errors = 0;

    ph1_cfg_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_target     (cfg_target),
        .cfg_last       (cfg_last),
        .cfg_data       (cfg_data),
        .commit_ok      (commit_ok),
        .coeff_bus      (coeff_bus),
        .wr_en          (wr_en),
        .iir_bypass_2_4 (iir_bypass_2_4),
        .iir_bypass_2   (iir_bypass_2),
        .iir_bypass_1   (iir_bypass_1),
        .flow_flags     (flow_flags),
        .sticky_flags   (sticky_flags),
        .sticky_clr     (sticky_clr),
        .cfg_done       (cfg_done),
        .cfg_err        (cfg_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] tgt, input logic [W-1:0] d, input logic last);
        cfg_valid  = 1'b1;
        cfg_target = tgt;
        cfg_data   = d;
        cfg_last   = last;
        step();
        cfg_valid  = 1'b0;
        cfg_last   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_en !== 7'd0 || cfg_done !== 1'b0 || cfg_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl wr_en=%h done=%b err=%b busy=%b required 00/0/0/0",
                     wr_en, cfg_done, cfg_err, busy);
        end
        checks++;
        if (coeff_bus !== '0) begin
            errors++;
            $display("FAIL reset_coeff_bus nonzero, required all 0");
        end
        checks++;
        if ({iir_bypass_1, iir_bypass_2, iir_bypass_2_4} !== 3'b000 || sticky_flags !== 8'h00) begin
            errors++;
            $display("FAIL reset_status byp=%b sticky=%h required 000/00",
                     {iir_bypass_1, iir_bypass_2, iir_bypass_2_4}, sticky_flags);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", cfg_ready);
        end
        step();
    endtask

    task automatic test_frac_load(input logic [W-1:0] base);
        int not_rdy = 0;
        logic [W-1:0] exp0;
        logic [W-1:0] exp71;
        exp0  = base + 20'd1;
        exp71 = base + 20'd72;
        commit_ok = 1'b1;
        for (int i = 0; i < NT; i++) begin
            if (cfg_ready !== 1'b1) not_rdy++;
            send(3'd0, base + W'(i + 1), (i == NT - 1));
        end
        checks++;
        if (not_rdy != 0) begin
            errors++;
            $display("FAIL frac_ready_during_load not-ready words=%0d required 0", not_rdy);
        end
        // T+1: CHECK
        checks++;
        if (cfg_ready !== 1'b0 || busy !== 1'b1 || wr_en !== 7'd0) begin
            errors++;
            $display("FAIL frac_check_state rdy=%b busy=%b wr_en=%h required 0/1/00",
                     cfg_ready, busy, wr_en);
        end
        step();
        checks++;
        if (wr_en !== 7'd0 || cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL frac_wait_state wr_en=%h done=%b required 00/0", wr_en, cfg_done);
        end
        step();
        checks++;
        if (wr_en !== 7'h01 || cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL frac_commit wr_en=%h done=%b required 01/1", wr_en, cfg_done);
        end
        checks++;
        if (coeff_bus[0 +: W] !== exp0 || coeff_bus[71*W +: W] !== exp71) begin
            errors++;
            $display("FAIL frac_coeff e0=%h e71=%h required %h/%h",
                     coeff_bus[0 +: W], coeff_bus[71*W +: W], exp0, exp71);
        end
        step();
        checks++;
        if (wr_en !== 7'd0 || cfg_done !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frac_after_commit wr_en=%h done=%b rdy=%b busy=%b required 00/0/1/0",
                     wr_en, cfg_done, cfg_ready, busy);
        end
    endtask

    task automatic test_commit_hold();
        int bad = 0;
        commit_ok = 1'b0;
        send(3'd4, 20'h12345, 1'b0);
        send(3'd4, 20'hFEDCB, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (cfg_ready !== 1'b0 || busy !== 1'b1 || wr_en !== 7'd0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_waiting bad cycles=%0d required 0", bad);
        end
        commit_ok = 1'b1;
        step();
        checks++;
        if (wr_en !== 7'b0010000 || cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL hold_commit wr_en=%b done=%b required 0010000/1", wr_en, cfg_done);
        end
        checks++;
        if (coeff_bus[0 +: W] !== 20'h12345 || coeff_bus[W +: W] !== 20'hFEDCB
            || coeff_bus[2*W +: W] !== 20'h00003) begin
            errors++;
            $display("FAIL hold_coeff e0=%h e1=%h e2=%h required 12345/fedcb/00003",
                     coeff_bus[0 +: W], coeff_bus[W +: W], coeff_bus[2*W +: W]);
        end
        step();
        checks++;
        if (wr_en !== 7'd0) begin
            errors++;
            $display("FAIL hold_pulse_width wr_en=%h required 00", wr_en);
        end
    endtask

    task automatic test_short_bank();
        commit_ok = 1'b1;
        send(3'd1, 20'h00011, 1'b0);
        send(3'd1, 20'h00022, 1'b1);
        step();
        checks++;
        if (cfg_err !== 1'b1 || wr_en !== 7'd0 || cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL short_err err=%b wr_en=%h done=%b required 1/00/0", cfg_err, wr_en, cfg_done);
        end
        step();
        checks++;
        if (cfg_ready !== 1'b1 || cfg_err !== 1'b0 || busy !== 1'b0 || wr_en !== 7'd0) begin
            errors++;
            $display("FAIL short_idle rdy=%b err=%b busy=%b wr_en=%h required 1/0/0/00",
                     cfg_ready, cfg_err, busy, wr_en);
        end
    endtask

    task automatic test_target_switch();
        send(3'd3, 20'h00007, 1'b0);
        send(3'd5, 20'h00008, 1'b0);
        checks++;
        if (cfg_err !== 1'b1 || cfg_ready !== 1'b0 || wr_en !== 7'd0) begin
            errors++;
            $display("FAIL switch_err err=%b rdy=%b wr_en=%h required 1/0/00", cfg_err, cfg_ready, wr_en);
        end
        step();
        checks++;
        if (cfg_err !== 1'b0 || cfg_ready !== 1'b1 || wr_en !== 7'd0) begin
            errors++;
            $display("FAIL switch_idle err=%b rdy=%b wr_en=%h required 0/1/00", cfg_err, cfg_ready, wr_en);
        end
    endtask

    task automatic test_bypass();
        commit_ok = 1'b1;
        send(3'd7, 20'h00005, 1'b1);
        step();
        step();
        checks++;
        if ({iir_bypass_1, iir_bypass_2, iir_bypass_2_4} !== 3'b101 || cfg_done !== 1'b1
            || wr_en !== 7'd0) begin
            errors++;
            $display("FAIL bypass_commit byp=%b done=%b wr_en=%h required 101/1/00",
                     {iir_bypass_1, iir_bypass_2, iir_bypass_2_4}, cfg_done, wr_en);
        end
        step();
    endtask

    task automatic test_sticky();
        flow_flags = 8'h04;
        step();
        flow_flags = 8'h00;
        checks++;
        if (sticky_flags !== 8'h04) begin
            errors++;
            $display("FAIL sticky_set got %h required 04", sticky_flags);
        end
        repeat (3) step();
        checks++;
        if (sticky_flags !== 8'h04) begin
            errors++;
            $display("FAIL sticky_hold got %h required 04", sticky_flags);
        end
        sticky_clr = 1'b1;
        flow_flags = 8'h04;
        step();
        sticky_clr = 1'b0;
        flow_flags = 8'h00;
        checks++;
        if (sticky_flags !== 8'h04) begin
            errors++;
            $display("FAIL sticky_set_wins got %h required 04", sticky_flags);
        end
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        checks++;
        if (sticky_flags !== 8'h00) begin
            errors++;
            $display("FAIL sticky_clear got %h required 00", sticky_flags);
        end
    endtask

    task automatic test_reset_mid_load();
        flow_flags = 8'hA5;
        step();
        flow_flags = 8'h00;
        checks++;
        if (sticky_flags !== 8'hA5) begin
            errors++;
            $display("FAIL midrst_sticky_pre got %h required a5", sticky_flags);
        end
        for (int i = 0; i < 40; i++) begin
            send(3'd0, W'(i + 1), 1'b0);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (wr_en !== 7'd0 || busy !== 1'b0 || cfg_done !== 1'b0 || cfg_err !== 1'b0
            || coeff_bus !== '0) begin
            errors++;
            $display("FAIL midrst_ctrl wr_en=%h busy=%b done=%b err=%b bus_nonzero=%b required 00/0/0/0/0",
                     wr_en, busy, cfg_done, cfg_err, (coeff_bus != '0));
        end
        checks++;
        if ({iir_bypass_1, iir_bypass_2, iir_bypass_2_4} !== 3'b000 || sticky_flags !== 8'h00) begin
            errors++;
            $display("FAIL midrst_status byp=%b sticky=%h required 000/00",
                     {iir_bypass_1, iir_bypass_2, iir_bypass_2_4}, sticky_flags);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || wr_en !== 7'd0) begin
            errors++;
            $display("FAIL midrst_release rdy=%b busy=%b wr_en=%h required 1/0/00", cfg_ready, busy, wr_en);
        end
        step();
        test_frac_load(20'h80000);
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_target = 3'd0;
        cfg_last   = 1'b0;
        cfg_data   = '0;
        commit_ok  = 1'b1;
        flow_flags = 8'h00;
        sticky_clr = 1'b0;

        test_reset();
        test_frac_load(20'h00000);
        test_commit_hold();
        test_short_bank();
        test_target_switch();
        test_bypass();
        test_sticky();
        test_reset_mid_load();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ph1_cfg_ctrl.md
Name: ph1_cfg_ctrl

Overview:
- Configuration sequencer for the Phase 1 chain: fractional decimator, then IIR stages 2.4 MHz, 2 MHz and 1 MHz.
- Accepts a word-serial coefficient stream over a valid/ready handshake and assembles each bank in a shadow register file.
- Commits a complete bank to the datapath with a single-cycle write-enable pulse, only at a safe point signalled by the chain.
- Also owns the three IIR bypass bits and sticky overflow/underflow status for the chain.

Parameters:
COEFF_WIDTH, 20, coefficient word width (signed, Q2.18)
N_TAP, 72, fractional decimator tap count
NUM_COEFF_DEPTH, 3, IIR numerator coefficients per stage
DEN_COEFF_DEPTH, 2, IIR denominator coefficients per stage

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  coefficient word offered
cfg_ready  out  1  controller accepts word this cycle
cfg_target  in  3  0 FRAC, 1/2 IIR_2_4 num/den, 3/4 IIR_2 num/den, 5/6 IIR_1 num/den, 7 BYPASS
cfg_last  in  1  final word of bank
cfg_data  in  COEFF_WIDTH  coefficient word; for BYPASS, bits[2:0] = {byp_1, byp_2, byp_2_4}
commit_ok  in  1  chain is at a safe update point
coeff_bus  out  N_TAP x COEFF_WIDTH  shadow bank; IIR targets use entries 0..depth-1
wr_en  out  7  one-hot per target 0..6, single-cycle pulse
iir_bypass_2_4, iir_bypass_2, iir_bypass_1  out  1 each  bypass controls
flow_flags  in  8  raw overflow/underflow flags: frac, 2_4, 2, 1 (ovf, unf pairs)
sticky_flags  out  8  latched flow_flags
sticky_clr  in  1  clears sticky_flags
cfg_done  out  1  pulse on commit
cfg_err  out  1  pulse on bank rejected
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-high) sets these and aborts any partial load with no wr_en pulse:
  - state IDLE, word count 0, coeff_bus all 0, wr_en 0
  - bypass bits 0, sticky_flags 0, cfg_done/cfg_err 0
  - cfg_ready is 1 once reset deasserts.
- A transfer occurs on cfg_valid && cfg_ready.
- States:
  - IDLE: cfg_ready=1. On a transfer, latch cfg_target, write cfg_data to shadow[0], count=1, then:
    - cfg_last set → CHECK
    - otherwise → LOAD
  - LOAD: cfg_ready=1. Each transfer writes shadow[count], count++.
    - If cfg_target differs from the latched target → ERR.
    - If count reaches expected and cfg_last is clear → ERR on that word.
    - cfg_last → CHECK.
  - CHECK (1 cycle): cfg_ready=0. Compare count to the expected length: N_TAP (target 0), NUM_COEFF_DEPTH (odd targets 1/3/5), DEN_COEFF_DEPTH (even targets 2/4/6), 1 (target 7).
    - Mismatch → ERR.
    - Match → WAIT_SAFE.
  - WAIT_SAFE: cfg_ready=0. Holds indefinitely until commit_ok=1 → COMMIT.
  - COMMIT (1 cycle): assert wr_en[target] (or update the bypass bits for target 7) and pulse cfg_done; → IDLE.
  - ERR (1 cycle): pulse cfg_err; shadow keeps stale data; no wr_en; → IDLE.
- Latency: last word accepted at cycle T; CHECK at T+1; commit_ok seen in WAIT_SAFE at T+2; wr_en/cfg_done registered at T+3 minimum.
- coeff_bus is stable from CHECK through COMMIT. Shadow entries beyond the loaded count are unchanged.
- Shadow writes in LOAD index with count; a write at count ≥ N_TAP is dropped (never wraps) and the bank is rejected.
- sticky_flags: each bit is set by flow_flags and cleared by sticky_clr. Simultaneous set and clear → set wins.
- All outputs are registered.

Decomposition:
- Package ph1_cfg_pkg holds:
  - target enum (3-bit)
  - state enum
  - expected-length function of target and parameters
  - flag bit indices.
- One sub-module, ph1_sticky_status: 8-bit sticky set/clear register.

Test Plan:
- FRAC load: 72 words 0x00001..0x00048, last on word 72, commit_ok=1 → wr_en[0] pulse at T+3, coeff_bus[71]=0x00048, cfg_done=1 for 1 cycle.
- IIR_2 den load with commit_ok held low 50 cycles: 2 words → cfg_ready=0 and busy=1 throughout; wr_en[4] pulses exactly 1 cycle after commit_ok rises.
- Short bank: target 1 with cfg_last on word 2 → cfg_err pulse, wr_en stays 0, back to IDLE, cfg_ready=1 next cycle.
- Target switch mid-load (target 3 then 5) → cfg_err, no wr_en; bypass load data 3'b101 → iir_bypass_1=1, iir_bypass_2=0, iir_bypass_2_4=1 after commit.
- Reset asserted in LOAD at word 40 of FRAC → all outputs zero immediately, no wr_en; a subsequent full load succeeds.
- flow_flags[2] pulsed 1 cycle → sticky_flags[2]=1 persists; sticky_clr with a simultaneous flow_flags[2] pulse → stays 1; sticky_clr alone → 0.
